// File: rtl/atari_cart_pkg.sv
// Shared constants for the cartridge bank mapper.
// Bank/window widths, default hotspot base and RAM port decode.
package atari_cart_pkg;

  localparam int BANK_W     = 3;
  localparam int CART_WIN_W = 12;

  localparam logic [11:0] HOT_BASE_DFLT = 12'hFF4;

  localparam int RAM_AW    = 7;
  localparam int RAM_DEPTH = 128;

  localparam logic [3:0] RAM_REGION  = 4'h0;
  localparam logic [4:0] RAM_WR_PAGE = 5'b00000;
  localparam logic [4:0] RAM_RD_PAGE = 5'b00001;

  typedef enum logic {
    ARMED = 1'b0,
    HELD  = 1'b1
  } arm_e;

endpackage

// File: rtl/cart_ram.sv
// 128x8 cartridge RAM: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module cart_ram
  import atari_cart_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [RAM_AW-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cart_mapper.sv
// Hotspot bank-switching cartridge mapper with optional RAM.
// A hit loads the bank once per distinct access (edge-armed).
module cart_mapper
  import atari_cart_pkg::*;
#(
  parameter int          NUM_BANKS  = 8,
  parameter logic [11:0] HOT_BASE   = HOT_BASE_DFLT,
  parameter int          RESET_BANK = NUM_BANKS - 1,
  parameter int          RAM_EN     = 0
) (
  input  logic        MCLK,
  input  logic        RES_N,
  input  logic        EN,
  input  logic [12:0] A,
  input  logic        R_W,
  input  logic [7:0]  D_IN,
  input  logic [7:0]  ROM_D,
  output logic        ROM_CS,
  output logic [14:0] ROM_ADDR,
  output logic [7:0]  D_OUT,
  output logic [2:0]  BANK
);

  localparam logic [12:0] HOT_END =
    {1'b0, HOT_BASE} + 13'(NUM_BANKS);
  localparam logic [BANK_W-1:0] RST_BANK =
    BANK_W'(RESET_BANK);

  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [CART_WIN_W-1:0] held_q, held_d;
  arm_e                  state_q, state_d;

  logic [CART_WIN_W-1:0] off;
  logic                  hit;
  logic                  fire;
  logic                  ram_region;
  logic                  wr_port;
  logic                  rd_port;
  logic [7:0]            ram_rd;
  logic                  unused_off;

  assign off = A[11:0] - HOT_BASE;
  assign unused_off = ^off[CART_WIN_W-1:BANK_W];

  assign hit = (NUM_BANKS > 1) && A[12]
    && ({1'b0, A[11:0]} >= {1'b0, HOT_BASE})
    && ({1'b0, A[11:0]} < HOT_END);

  // HELD only re-fires when the hit address differs
  // from the one that caused the last load.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    bank_d  = bank_q;
    fire    = 1'b0;
    unique case (state_q)
      ARMED: fire = EN & hit;
      HELD:  fire = EN & hit & (A[11:0] != held_q);
    endcase
    if (EN && !hit) begin
      state_d = ARMED;
    end
    if (fire) begin
      state_d = HELD;
      held_d  = A[11:0];
      bank_d  = off[BANK_W-1:0];
    end
  end

  always_ff @(posedge MCLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q <= ARMED;
      held_q  <= '0;
      bank_q  <= RST_BANK;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      bank_q  <= bank_d;
    end
  end

  assign BANK     = bank_q;
  assign ROM_ADDR = {bank_q, A[11:0]};

  generate
    if (RAM_EN != 0) begin : g_ram
      logic ram_we;
      assign ram_region = (A[11:8] == RAM_REGION);
      assign wr_port = A[12] & (A[11:7] == RAM_WR_PAGE);
      assign rd_port = A[12] & (A[11:7] == RAM_RD_PAGE);
      assign ram_we  = EN & ~R_W & wr_port;
      cart_ram u_ram (
        .clk_i   (MCLK),
        .we_i    (ram_we),
        .addr_i  (A[6:0]),
        .wdata_i (D_IN),
        .rdata_o (ram_rd)
      );
    end else begin : g_no_ram
      logic unused_ram;
      assign ram_region = 1'b0;
      assign wr_port    = 1'b0;
      assign rd_port    = 1'b0;
      assign ram_rd     = 8'hFF;
      assign unused_ram = ^{R_W, D_IN};
    end
  endgenerate

  assign ROM_CS = A[12] & ~ram_region;

  always_comb begin
    D_OUT = ROM_D;
    if (rd_port) begin
      D_OUT = ram_rd;
    end else if (wr_port && R_W) begin
      D_OUT = 8'hFF;
    end
  end

endmodule

// File: tb/tb_cart_mapper.sv
// Bench for cart_mapper: directed table plus random stimulus
// against a reference model, over three parameter sets.
module tb_cart_mapper;

  logic        MCLK = 1'b0;
  logic        RES_N = 1'b0;
  logic        EN = 1'b0;
  logic        R_W = 1'b1;
  logic [12:0] A = '0;
  logic [7:0]  D_IN = '0;
  logic [7:0]  ROM_D = '0;

  logic        cs_o   [3];
  logic [14:0] addr_o [3];
  logic [7:0]  dout_o [3];
  logic [2:0]  bank_o [3];

  always #5 MCLK = ~MCLK;

  cart_mapper u0 (
    .MCLK(MCLK), .RES_N(RES_N), .EN(EN), .A(A),
    .R_W(R_W), .D_IN(D_IN), .ROM_D(ROM_D),
    .ROM_CS(cs_o[0]), .ROM_ADDR(addr_o[0]),
    .D_OUT(dout_o[0]), .BANK(bank_o[0])
  );

  cart_mapper #(.RAM_EN(1)) u1 (
    .MCLK(MCLK), .RES_N(RES_N), .EN(EN), .A(A),
    .R_W(R_W), .D_IN(D_IN), .ROM_D(ROM_D),
    .ROM_CS(cs_o[1]), .ROM_ADDR(addr_o[1]),
    .D_OUT(dout_o[1]), .BANK(bank_o[1])
  );

  cart_mapper #(.NUM_BANKS(4), .HOT_BASE(12'hFF6)) u2 (
    .MCLK(MCLK), .RES_N(RES_N), .EN(EN), .A(A),
    .R_W(R_W), .D_IN(D_IN), .ROM_D(ROM_D),
    .ROM_CS(cs_o[2]), .ROM_ADDR(addr_o[2]),
    .D_OUT(dout_o[2]), .BANK(bank_o[2])
  );

  int NB [3] = '{8, 8, 4};
  int HB [3] = '{'hFF4, 'hFF4, 'hFF6};
  int RB [3] = '{7, 7, 3};

  int checks = 0;
  int failures = 0;

  // Model: bank per instance, plus the address that last
  // loaded it (-1 once a non-hit access re-arms).
  int         mbank [3];
  int         mheld [3];
  logic [7:0] mram [128];
  bit         mvalid [128];

  typedef struct {
    bit          rst;
    bit          en;
    logic [12:0] a;
    bit          rw;
    logic [7:0]  din;
    logic [14:0] e_addr0;
    logic [2:0]  e_bank0;
    logic [2:0]  e_bank2;
    int          e_dout1;
    bit          e_cs1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    bit rst, bit en, logic [12:0] a, bit rw,
    logic [7:0] din, logic [14:0] ea0,
    logic [2:0] eb0, logic [2:0] eb2,
    int ed1, bit ec1);
    vec_t v;
    v.rst = rst; v.en = en; v.a = a; v.rw = rw;
    v.din = din; v.e_addr0 = ea0; v.e_bank0 = eb0;
    v.e_bank2 = eb2; v.e_dout1 = ed1; v.e_cs1 = ec1;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic bit is_hit(int i, logic [12:0] a);
    int off;
    off = int'(a[11:0]);
    return NB[i] > 1 && a[12] == 1'b1
      && off >= HB[i] && off < HB[i] + NB[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mbank[i] = RB[i];
      mheld[i] = -1;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (EN && is_hit(i, A)) begin
        if (mheld[i] != int'(A[11:0])) begin
          mbank[i] = int'(A[11:0]) - HB[i];
          mheld[i] = int'(A[11:0]);
        end
      end else if (EN) begin
        mheld[i] = -1;
      end
    end
    if (EN && !R_W && A[12] && A[11:7] == 5'd0) begin
      mram[A[6:0]] = D_IN;
      mvalid[A[6:0]] = 1'b1;
    end
  endtask

  task automatic check_comb(string tag);
    int ea;
    int ed;
    bit ecs;
    for (int i = 0; i < 3; i++) begin
      ecs = A[12] && !(i == 1 && A[11:8] == 4'h0);
      ea = mbank[i] * 4096 + int'(A[11:0]);
      ed = int'(ROM_D);
      if (i == 1 && A[12] && A[11:7] == 5'd1) begin
        ed = mvalid[A[6:0]] ? int'(mram[A[6:0]]) : -1;
      end else if (i == 1 && A[12] && A[11:7] == 5'd0
                   && R_W) begin
        ed = 'hFF;
      end
      chk($sformatf("%s cs%0d", tag, i),
          32'(cs_o[i]), 32'(ecs));
      chk($sformatf("%s addr%0d", tag, i),
          32'(addr_o[i]), ea);
      if (ed >= 0) begin
        chk($sformatf("%s dout%0d", tag, i),
            32'(dout_o[i]), ed);
      end
    end
  endtask

  task automatic cycle(bit rst, bit en, logic [12:0] a,
                       bit rw, logic [7:0] din,
                       logic [7:0] romd, string tag, int vi);
    vec_t v;
    @(negedge MCLK);
    RES_N = rst; EN = en; A = a; R_W = rw;
    D_IN = din; ROM_D = romd;
    if (!rst) model_reset();
    #2;
    check_comb(tag);
    if (vi >= 0) begin
      v = vt[vi];
      chk($sformatf("%s tbl_addr0", tag),
          32'(addr_o[0]), 32'(v.e_addr0));
      chk($sformatf("%s tbl_cs1", tag),
          32'(cs_o[1]), 32'(v.e_cs1));
      if (v.e_dout1 >= 0) begin
        chk($sformatf("%s tbl_dout1", tag),
            32'(dout_o[1]), v.e_dout1);
      end
    end
    @(posedge MCLK);
    if (rst) model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s bank%0d", tag, i),
          32'(bank_o[i]), mbank[i]);
    end
    if (vi >= 0) begin
      chk($sformatf("%s tbl_bank0", tag),
          32'(bank_o[0]), 32'(v.e_bank0));
      chk($sformatf("%s tbl_bank2", tag),
          32'(bank_o[2]), 32'(v.e_bank2));
    end
  endtask

  initial begin
    logic [12:0] a;
    int r;

    vt.push_back(mk(0,1,13'h1FF4,1,8'h00,15'h7FF4,7,3,'h3C,1));
    vt.push_back(mk(0,0,13'h1FFC,1,8'h00,15'h7FFC,7,3,'h3C,1));
    vt.push_back(mk(1,1,13'h1FFC,1,8'h00,15'h7FFC,7,3,'h3C,1));
    vt.push_back(mk(1,1,13'h1FF4,1,8'h00,15'h7FF4,0,3,'h3C,1));
    vt.push_back(mk(1,1,13'h1000,1,8'h00,15'h0000,0,3,'hFF,0));
    vt.push_back(mk(1,1,13'h1FF6,1,8'h00,15'h0FF6,2,0,'h3C,1));
    vt.push_back(mk(1,1,13'h1FF6,1,8'h00,15'h2FF6,2,0,'h3C,1));
    vt.push_back(mk(1,1,13'h1FF6,1,8'h00,15'h2FF6,2,0,'h3C,1));
    vt.push_back(mk(1,1,13'h1FF5,1,8'h00,15'h2FF5,1,0,'h3C,1));
    vt.push_back(mk(1,0,13'h1FF4,1,8'h00,15'h1FF4,1,0,'h3C,1));
    vt.push_back(mk(1,0,13'h1FF9,1,8'h00,15'h1FF9,1,0,'h3C,1));
    vt.push_back(mk(1,1,13'h1FF9,1,8'h00,15'h1FF9,5,3,'h3C,1));
    vt.push_back(mk(1,1,13'h1012,0,8'hA5,15'h5012,5,3,-1,0));
    vt.push_back(mk(1,1,13'h1092,1,8'h00,15'h5092,5,3,'hA5,0));
    vt.push_back(mk(1,1,13'h1012,1,8'h00,15'h5012,5,3,'hFF,0));
    vt.push_back(mk(1,1,13'h1092,1,8'h00,15'h5092,5,3,'hA5,0));
    vt.push_back(mk(1,1,13'h1092,0,8'h5A,15'h5092,5,3,-1,0));
    vt.push_back(mk(1,1,13'h1092,1,8'h00,15'h5092,5,3,'hA5,0));
    vt.push_back(mk(1,1,13'h0FF4,1,8'h00,15'h5FF4,5,3,'h3C,0));
    vt.push_back(mk(0,1,13'h1FF4,1,8'h00,15'h7FF4,7,3,'h3C,1));
    vt.push_back(mk(1,1,13'h1FFC,1,8'h00,15'h7FFC,7,3,'h3C,1));
    vt.push_back(mk(1,1,13'h1FFB,1,8'h00,15'h7FFB,7,3,'h3C,1));
    vt.push_back(mk(1,1,13'h1FF9,1,8'h00,15'h7FF9,5,3,'h3C,1));

    model_reset();
    for (int k = 0; k < 128; k++) mvalid[k] = 1'b0;

    for (int vi = 0; vi < vt.size(); vi++) begin
      cycle(vt[vi].rst, vt[vi].en, vt[vi].a, vt[vi].rw,
            vt[vi].din, 8'h3C, $sformatf("vec%0d", vi), vi);
    end

    a = 13'h1FF4;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        a = 13'h1FF0 + 13'($urandom_range(0, 15));
      end else if (r <= 5) begin
        a = 13'h1000 + 13'($urandom_range(0, 255));
      end else if (r == 6) begin
        a = 13'($urandom());
      end
      cycle($urandom_range(0, 63) != 0,
            $urandom_range(0, 3) != 0, a,
            1'($urandom()), 8'($urandom()),
            8'($urandom()), $sformatf("rnd%0d", n), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/cart_mapper.md
CART_MAPPER -- requirements
Module: cart_mapper

Interface
REQ-001 Parameter NUM_BANKS, default 8, meaning: number of 4 KiB ROM banks; legal values 1, 2, 4 and 8.
REQ-002 Parameter HOT_BASE, default 12'hFF4, meaning: first hotspot offset inside the cartridge window; HOT_BASE+NUM_BANKS-1 SHALL NOT exceed 12'hFFF.
REQ-003 Parameter RESET_BANK, default NUM_BANKS-1, meaning: bank selected after reset.
REQ-004 Parameter RAM_EN, default 0, meaning: when 1, enables 128x8 cartridge RAM (write port $1000-$107F, read port $1080-$10FF).
REQ-005 MCLK  in  1  machine clock; all state updates on rising edge.
REQ-006 RES_N  in  1  reset; asynchronous, active-low.
REQ-007 EN  in  1  qualified bus cycle (CPU cycle advancing, RDY high).
REQ-008 A  in  13  CPU address bits [12:0]; A[12]=1 selects the cartridge.
REQ-009 R_W  in  1  read(1)/write(0).
REQ-010 D_IN  in  8  CPU write data.
REQ-011 ROM_D  in  8  data from external ROM.
REQ-012 ROM_CS  out  1  external ROM chip select.
REQ-013 ROM_ADDR  out  15  {bank[2:0], A[11:0]}; unused bank bits are 0.
REQ-014 D_OUT  out  8  read data to CPU.
REQ-015 BANK  out  3  current bank register.

Function
REQ-016 Hotspot hit = A[12] & (A[11:0] >= HOT_BASE) & (A[11:0] < HOT_BASE+NUM_BANKS), for reads and writes alike; with NUM_BANKS=1 there are no hotspots.
REQ-017 Bank register loads A[11:0]-HOT_BASE on the rising MCLK edge that ends a qualified hit cycle.
REQ-018 ROM_ADDR and D_OUT during the hit cycle itself use the old bank; the new bank applies from the next cycle.
REQ-019 Edge-triggered arming: FSM ARMED/HELD; a hit with EN=1 in ARMED switches the bank and moves to HELD.
REQ-020 HELD returns to ARMED when EN=1 with a non-hit address, or when A changes; repeated identical hit cycles, such as an RDY stall, cause no further loads.
REQ-021 EN=0 SHALL never change the bank, the RAM or the FSM state.
REQ-022 ROM_CS = A[12] & ~ram_region, where ram_region = RAM_EN & (A[11:8]==4'h0).
REQ-023 RAM write: EN & ~R_W & A[12] & (A[11:7]==5'b00000) writes D_IN to RAM[A[6:0]] at the cycle-ending edge.
REQ-024 RAM read: A[12] & (A[11:7]==5'b00001) gives D_OUT = RAM[A[6:0]], read combinationally in the same cycle.
REQ-025 A read from the write port gives D_OUT = 8'hFF and SHALL NOT modify the RAM.
REQ-026 A write to the read port is ignored.
REQ-027 In all other cases D_OUT = ROM_D.
REQ-028 A hotspot inside the RAM region is impossible for legal HOT_BASE; no priority between the two is needed.
REQ-029 The RAM logic is absent when RAM_EN=0.

Reset
REQ-030 While RES_N=0: BANK=RESET_BANK, FSM=ARMED, ROM_ADDR={RESET_BANK,A[11:0]}.
REQ-031 RAM contents are not reset and are undefined after power-up.
REQ-032 Reset asserted in the middle of a hit cycle wins: the bank stays RESET_BANK.
REQ-033 After reset deasserts, the first edge behaves as ARMED.

Structure
REQ-034 The package atari_cart_pkg SHALL hold BANK_W=3, CART_WIN_W=12, the default HOT_BASE, and the RAM region constants.
REQ-035 One sub-module, cart_ram: 128x8, synchronous write, asynchronous read; instantiated only under RAM_EN.

Verification
REQ-036 Reset with NUM_BANKS=8 -> BANK=7; read $1FFC -> ROM_ADDR=15'h7FFC.
REQ-037 Read $1FF4 with EN=1 -> ROM_ADDR=15'h7FF4 in that cycle; next read $1000 -> ROM_ADDR=15'h0000, BANK=0.
REQ-038 Hit $1FF6 held 3 cycles (EN=1, unchanged A), then read $1FF5 -> BANK=2 after the first cycle, then BANK=1 after $1FF5.
REQ-039 RAM_EN=1: write 8'hA5 to $1012, then read $1092 -> D_OUT=8'hA5, ROM_CS=0; read $1012 -> D_OUT=8'hFF, RAM unchanged.
REQ-040 NUM_BANKS=4, HOT_BASE=12'hFF6: access $1FF4 -> no bank change; access $1FF9 -> BANK=3.
REQ-041 RES_N low during a $1FF4 hit cycle -> BANK=7 after reset release; EN=0 with A=$1FF4 -> BANK unchanged.
